// File: rtl/shift_reg_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// sr_ops : shared definitions for the 4-bit universal register and its
//          command sequencer.
//
// Contents
//   OP_*     register select codes (sel input of the universal register)
//   state_t  sequencer FSM state encoding (S_IDLE / S_RUN / S_DONE)
//   helpers  small pure functions shared by the register-side logic
// -----------------------------------------------------------------------------
package sr_ops;

    // Register select codes. The sequencer never decodes these; it only
    // forwards them, so any 3-bit value is legal on the command side.
    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    // Sequencer FSM encoding.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // True when an op code leaves the register contents untouched.
    function automatic logic op_is_hold(input logic [2:0] op);
        return (op == OP_HOLD);
    endfunction

endpackage : sr_ops

// File: rtl/shift_reg_sequencer_if.sv
// -----------------------------------------------------------------------------
// shift_reg_sequencer_if : command channel into the shift-register sequencer.
//
// Handshake
//   A command transfers on a rising clock edge where cmd_valid and cmd_ready
//   are both high. The master holds cmd_op/cmd_data/cmd_cnt stable while
//   cmd_valid is high; cmd_ready does not depend combinationally on
//   cmd_valid. cmd_abort is a level sampled only while a run is in progress
//   and is not part of the valid/ready transfer.
//
// Signals
//   cmd_valid  master -> slave  command offered
//   cmd_ready  slave  -> master sequencer can accept a command
//   cmd_op     master -> slave  register op code
//   cmd_data   master -> slave  operand / serial-in source
//   cmd_cnt    master -> slave  number of cycles to apply the op
//   cmd_abort  master -> slave  terminate the current run early
// -----------------------------------------------------------------------------
interface shift_reg_sequencer_if #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 4
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic [CNT_W-1:0]  cmd_cnt;
    logic              cmd_abort;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        output cmd_cnt,
        output cmd_abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        input  cmd_cnt,
        input  cmd_abort,
        output cmd_ready
    );

endinterface : shift_reg_sequencer_if

// File: rtl/shift_reg_sequencer_counter.sv
// -----------------------------------------------------------------------------
// seq_down_counter : run-length counter for the shift-register sequencer.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   load       in   load load_val (takes priority over dec)
//   load_val   in   CNT_W  initial remaining count
//   dec        in   decrement by one (saturates at zero)
//   remaining  out  CNT_W  cycles left in the current run
//   last       out  registered (remaining == 1)
//
// 'last' is computed from the value being written so it is valid in the same
// cycle as 'remaining' without a comparator on the FSM's critical path.
// -----------------------------------------------------------------------------
module seq_down_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] remaining,
    output logic             last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            last      <= 1'b0;
        end else if (load) begin
            remaining <= load_val;
            last      <= (load_val == CNT_W'(1));
        end else if (dec && (remaining != '0)) begin
            remaining <= remaining - CNT_W'(1);
            // After this decrement the count will be 1 iff it is 2 now.
            last      <= (remaining == CNT_W'(2));
        end
    end

endmodule : seq_down_counter

// File: rtl/shift_reg_sequencer.sv
// -----------------------------------------------------------------------------
// shift_reg_sequencer : command-driven controller for the 4-bit universal
// register. Accepts one {op, data, count} command, drives the register's
// sel/d_in for exactly 'count' cycles, then pulses done for one cycle.
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-low reset
//   cmd            slave modport of shift_reg_sequencer_if (command channel)
//   reg_sel        out  3       register select; OP_HOLD whenever not running
//   reg_d_in       out  DATA_W  register data input; holds the last accepted
//                               data until the next accept
//   busy           out  high in RUN and DONE
//   done           out  one-cycle completion pulse
//   aborted        out  qualifies done: run was cut short by cmd_abort
//   dbg_state      out  current FSM state
//   dbg_remaining  out  CNT_W   cycles left in the current run
//
// Every output is a flop; nothing on the command side reaches reg_* without
// passing through a register. The next value of each output is derived from
// the next FSM state in a single combinational process.
// -----------------------------------------------------------------------------
module shift_reg_sequencer
    import sr_ops::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    shift_reg_sequencer_if.slave  cmd,
    output logic [2:0]            reg_sel,
    output logic [DATA_W-1:0]     reg_d_in,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output state_t                dbg_state,
    output logic [CNT_W-1:0]      dbg_remaining
);

    state_t              state_q, state_n;
    logic                ready_q, ready_n;
    logic [2:0]          sel_n;
    logic [DATA_W-1:0]   d_n;
    logic                busy_n;
    logic                done_n;
    logic                aborted_n;

    logic                cnt_load;
    logic                cnt_dec;
    logic [CNT_W-1:0]    cnt_remaining;
    logic                cnt_last;

    logic                accept;

    assign accept        = cmd.cmd_valid && ready_q;
    assign cmd.cmd_ready = ready_q;
    assign dbg_state     = state_q;
    assign dbg_remaining = cnt_remaining;

    seq_down_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk       (clk),
        .rst_n     (reset),
        .load      (cnt_load),
        .load_val  (cmd.cmd_cnt),
        .dec       (cnt_dec),
        .remaining (cnt_remaining),
        .last      (cnt_last)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b1;
            reg_sel  <= OP_HOLD;
            reg_d_in <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            state_q  <= state_n;
            ready_q  <= ready_n;
            reg_sel  <= sel_n;
            reg_d_in <= d_n;
            busy     <= busy_n;
            done     <= done_n;
            aborted  <= aborted_n;
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        state_n   = state_q;
        ready_n   = 1'b0;
        sel_n     = OP_HOLD;
        d_n       = reg_d_in;
        busy_n    = 1'b0;
        done_n    = 1'b0;
        aborted_n = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_n = 1'b1;
                if (accept) begin
                    d_n     = cmd.cmd_data;
                    ready_n = 1'b0;
                    busy_n  = 1'b1;
                    if (cmd.cmd_cnt != '0) begin
                        state_n  = S_RUN;
                        sel_n    = cmd.cmd_op;
                        cnt_load = 1'b1;
                    end else begin
                        // Zero-length command: report completion without
                        // ever touching the register.
                        state_n = S_DONE;
                        done_n  = 1'b1;
                    end
                end
            end

            S_RUN: begin
                cnt_dec = 1'b1;
                busy_n  = 1'b1;
                // Abort wins over the natural end of the run so that a
                // simultaneous abort on the last cycle is still reported.
                if (cmd.cmd_abort) begin
                    state_n   = S_DONE;
                    done_n    = 1'b1;
                    aborted_n = 1'b1;
                end else if (cnt_last) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                end else begin
                    // reg_sel itself carries the op for the rest of the run.
                    sel_n = reg_sel;
                end
            end

            S_DONE: begin
                state_n = S_IDLE;
                ready_n = 1'b1;
            end

            default: begin
                state_n = S_IDLE;
                ready_n = 1'b1;
            end
        endcase

        // A run of the hold code is still a run; this only guards against a
        // stale non-hold select surviving outside RUN.
        if ((state_n != S_RUN) && !op_is_hold(sel_n)) begin
            sel_n = OP_HOLD;
        end
    end

endmodule : shift_reg_sequencer
